spi_fsm: RTL
============

Name: spi_fsm

Overview:
- Transaction controller for the SPI memory datapath.
- Consumes conditioned chip select, SCLK edge pulses and the shift register's R/W bit.
- Produces the one-cycle write strobes that load the shift register, latch the address and write data memory, plus the MISO buffer enable.
- Sits directly downstream of the input conditioners and beside the 8-bit shift register it sequences.

Parameters:
- WORD_BITS, 8, bits per SPI field (address+R/W byte, data byte); counter width is clog2(WORD_BITS)+1.

Ports:
- Clk  input  1  system clock; all state changes on rising edge.
- nReset  input  1  asynchronous, active-low reset.
- csConditioned  input  1  conditioned chip select, active low (0 = transaction in progress).
- sclkPosEdge  input  1  one-Clk pulse per SCLK rising edge (same pulse that shifts the shift register).
- rwBit  input  1  shift register parallel output bit 0; 1 = read, 0 = write; valid the cycle after the 8th address edge.
- addrWE  output  1  one-cycle strobe: latch parallel-out[7:1] into address latch.
- srWE  output  1  one-cycle strobe: parallel-load shift register from data memory.
- dmWE  output  1  one-cycle strobe: write shift register parallel-out into data memory.
- misoBufEn  output  1  enables the MISO tri-state buffer.
- state  output  3  current state encoding, for debug/verification.

Behaviour:
- Reset state:
  - nReset=0 immediately forces state=IDLE and bit counter=0.
  - All strobes, misoBufEn and state read 0 (IDLE encodes as 0).
- Output decoding:
  - All outputs are Moore-decoded from the state register only; no combinational path from inputs.
- States and transitions:
  - IDLE: csConditioned=0 -> GET_ADDR with counter cleared.
  - GET_ADDR: each sclkPosEdge increments counter. On the pulse that makes counter==WORD_BITS -> GOT_ADDR.
  - GOT_ADDR (1 cycle): addrWE=1. rwBit=1 -> READ_LOAD; rwBit=0 -> WRITE_GET. Counter cleared on exit.
  - READ_LOAD (1 cycle): srWE=1. Data memory read is combinational from the latched address. -> READ_SEND.
  - READ_SEND: misoBufEn=1. Count sclkPosEdge. On the WORD_BITS-th pulse -> DONE.
  - WRITE_GET: count sclkPosEdge. On the WORD_BITS-th pulse -> WRITE_STORE.
  - WRITE_STORE (1 cycle): dmWE=1. -> DONE.
  - DONE: all outputs 0. sclkPosEdge ignored. Waits for csConditioned=1.
- Chip-select deassert:
  - csConditioned=1 in any non-IDLE state -> IDLE next cycle, counter cleared.
  - This has priority over every other transition, including the cycle carrying the 8th edge and the single-cycle strobe states.
  - An aborted write never asserts dmWE.
- Latency:
  - addrWE rises exactly 1 Clk after the 8th address sclkPosEdge pulse.
  - srWE follows addrWE by 1 Clk; misoBufEn follows srWE by 1 Clk.
  - dmWE rises 1 Clk after the 8th data pulse.
- Counter:
  - Saturating use only; never wraps within a field, because the state exits on reaching WORD_BITS.
  - Counts only in GET_ADDR, READ_SEND and WRITE_GET; held at 0 elsewhere.
- Edge pulses while in IDLE, GOT_ADDR, READ_LOAD, WRITE_STORE or DONE are ignored. They are not counted.
- Back-to-back transactions require csConditioned to return high for at least one Clk.
- Reset asserted mid-transaction: immediate IDLE, no strobe emitted; resumes only on a fresh CS low.

Decomposition:
- Package spi_fsm_pkg holds:
  - state encodings: IDLE=0, GET_ADDR=1, GOT_ADDR=2, READ_LOAD=3, READ_SEND=4, WRITE_GET=5, WRITE_STORE=6, DONE=7;
  - WORD_BITS default constant.
- One natural sub-module: spi_bit_counter (clear, enable, count output, done flag at WORD_BITS).

Test Plan:
- Reset: hold nReset=0 with CS low and edge pulses -> state=0 and all outputs 0 throughout; release -> GET_ADDR only after the next CS-low cycle.
- Write: CS low, 8 address pulses with rwBit sampled 0, then 8 data pulses.
  - addrWE high exactly 1 cycle, 1 Clk after pulse 8.
  - dmWE high exactly 1 cycle, 1 Clk after data pulse 8.
  - srWE and misoBufEn never high.
- Read: CS low, 8 pulses with rwBit=1.
  - Sequence is addrWE, srWE, misoBufEn on consecutive cycles.
  - misoBufEn stays high through 8 more pulses, then drops to 0 (DONE) while CS is still low.
- Abort: CS high on the same cycle as data pulse 8 of a write -> next state IDLE, dmWE never asserted. A new transaction then completes normally.
- Extra edges: 3 sclkPosEdge pulses in DONE, then CS high, then a full write -> exactly one dmWE, and the address counter starts from 0.
- Async reset mid-READ_SEND (after 4 pulses), asserted between Clk edges -> outputs drop to 0 before the next Clk edge; state=IDLE.

Source files
------------

// File: rtl/spi_fsm_pkg.sv
// ----------------------------------------------------------------------------
// spi_fsm_pkg
// Shared definitions for the SPI memory transaction controller:
//   - state encodings (also exported on the debug 'state' port)
//   - default field width in bits
//   - output bundle type and the Moore output decoder
// ----------------------------------------------------------------------------
package spi_fsm_pkg;

    localparam int WORD_BITS_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        GET_ADDR    = 3'd1,
        GOT_ADDR    = 3'd2,
        READ_LOAD   = 3'd3,
        READ_SEND   = 3'd4,
        WRITE_GET   = 3'd5,
        WRITE_STORE = 3'd6,
        DONE        = 3'd7
    } state_e;

    typedef struct packed {
        logic addr_we;
        logic sr_we;
        logic dm_we;
        logic miso_buf_en;
    } outs_t;

    // Output bundle belonging to a given state; every output depends on state only.
    function automatic outs_t decode_outputs(input state_e s);
        outs_t o;
        o = '0;
        case (s)
            GOT_ADDR:    o.addr_we     = 1'b1;
            READ_LOAD:   o.sr_we       = 1'b1;
            READ_SEND:   o.miso_buf_en = 1'b1;
            WRITE_STORE: o.dm_we       = 1'b1;
            default:     o             = '0;
        endcase
        return o;
    endfunction

    // States in which SCLK rising edges advance the bit counter.
    function automatic logic is_counting(input state_e s);
        return (s == GET_ADDR) || (s == READ_SEND) || (s == WRITE_GET);
    endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// ----------------------------------------------------------------------------
// spi_bit_counter
// Counts SCLK edge pulses within one SPI field. Saturates at WORD_BITS.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear (wins over enable)
//   enable     : count one pulse this cycle
//   count      : current count, width clog2(WORD_BITS)+1
//   done       : count has reached WORD_BITS
// ----------------------------------------------------------------------------
module spi_bit_counter
    import spi_fsm_pkg::*;
#(
    parameter int WORD_BITS = WORD_BITS_DEFAULT,
    localparam int CNT_W    = $clog2(WORD_BITS) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    logic [CNT_W-1:0] count_r;

    // Pulse counter: clear has priority, saturate instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable && (count_r != CNT_W'(WORD_BITS))) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign done  = (count_r == CNT_W'(WORD_BITS));

endmodule

// File: rtl/spi_fsm.sv
// ----------------------------------------------------------------------------
// spi_fsm
// Transaction controller for the SPI memory datapath. Sequences the address
// byte (7-bit address + R/W bit) and the following data byte, and generates
// the one-cycle strobes for the address latch, shift register load and data
// memory write, plus the MISO buffer enable.
// Ports:
//   Clk           : system clock
//   nReset        : asynchronous active-low reset
//   csConditioned : conditioned chip select, 0 = transaction in progress
//   sclkPosEdge   : one-Clk pulse per SCLK rising edge
//   rwBit         : shift register bit 0 (1 = read), valid in GOT_ADDR
//   addrWE        : latch address strobe
//   srWE          : shift register parallel-load strobe
//   dmWE          : data memory write strobe
//   misoBufEn     : MISO tri-state enable
//   state         : current state encoding (debug)
// ----------------------------------------------------------------------------
module spi_fsm
    import spi_fsm_pkg::*;
#(
    parameter int WORD_BITS = WORD_BITS_DEFAULT
) (
    input  logic       Clk,
    input  logic       nReset,
    input  logic       csConditioned,
    input  logic       sclkPosEdge,
    input  logic       rwBit,
    output logic       addrWE,
    output logic       srWE,
    output logic       dmWE,
    output logic       misoBufEn,
    output logic [2:0] state
);

    localparam int CNT_W = $clog2(WORD_BITS) + 1;

    state_e           state_r;
    state_e           next_state_s;
    outs_t            outs_r;
    logic [CNT_W-1:0] bit_count_s;
    logic             cnt_done_s;
    logic             cnt_clear_s;
    logic             cnt_enable_s;
    logic             field_end_s;

    // A field ends on the pulse that brings the count to WORD_BITS. A count
    // already sitting at WORD_BITS is treated as field end too, so a corrupted
    // counter can never park the FSM in a counting state.
    assign field_end_s = (sclkPosEdge && (bit_count_s == CNT_W'(WORD_BITS - 1)))
                       || cnt_done_s;

    // Count only in counting states; any state change restarts the count at 0.
    assign cnt_enable_s = is_counting(state_r) && sclkPosEdge;
    assign cnt_clear_s  = !is_counting(state_r) || (next_state_s != state_r);

    spi_bit_counter #(
        .WORD_BITS (WORD_BITS)
    ) u_bit_counter (
        .clk    (Clk),
        .rst_n  (nReset),
        .clear  (cnt_clear_s),
        .enable (cnt_enable_s),
        .count  (bit_count_s),
        .done   (cnt_done_s)
    );

    // Next-state selection; chip-select release overrides every other transition.
    always_comb begin
        next_state_s = state_r;
        if (csConditioned) begin
            next_state_s = IDLE;
        end else begin
            case (state_r)
                IDLE:        next_state_s = GET_ADDR;
                GET_ADDR:    next_state_s = field_end_s ? GOT_ADDR : GET_ADDR;
                GOT_ADDR:    next_state_s = rwBit ? READ_LOAD : WRITE_GET;
                READ_LOAD:   next_state_s = READ_SEND;
                READ_SEND:   next_state_s = field_end_s ? DONE : READ_SEND;
                WRITE_GET:   next_state_s = field_end_s ? WRITE_STORE : WRITE_GET;
                WRITE_STORE: next_state_s = DONE;
                DONE:        next_state_s = DONE;
                default:     next_state_s = IDLE;
            endcase
        end
    end

    // State register with outputs registered alongside it, so each output is
    // a pure function of the state held in the flops and reset clears both.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_r <= IDLE;
            outs_r  <= '0;
        end else begin
            state_r <= next_state_s;
            outs_r  <= decode_outputs(next_state_s);
        end
    end

    assign addrWE    = outs_r.addr_we;
    assign srWE      = outs_r.sr_we;
    assign dmWE      = outs_r.dm_we;
    assign misoBufEn = outs_r.miso_buf_en;
    assign state     = state_r;

endmodule
